fetch_decode_latch: RTL and testbench

- IF/ID boundary register between the fetch stage and the decode stage.
- Captures the fetch-cycle PC and PC+4, and aligns them with the synchronous instruction-memory read data.
- Holds the instruction across stalls, kills it on a taken branch or jump, and performs load-use hazard detection.
- Drives PC_WRITE back to the fetch stage and a bubble request to the ID/EX register.

---
 rtl/fetch_decode_latch.sv | 100 ++++++++++
 tb/tb_fetch_decode_latch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_latch.sv
// rtl/fetch_decode_latch.sv - IF/ID boundary register with instruction hold, flush and load-use stall
module fetch_decode_latch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        ID_CLK,
  input  logic        ID_RESET_N,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_PC_PLUS_FOUR,
  input  logic [31:0] IMEM_DOUT,
  input  logic        FLUSH,
  input  logic        EX_MEM_READ,
  input  logic [4:0]  EX_RD,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_PLUS_FOUR,
  output logic [31:0] ID_INSTR,
  output logic        ID_VALID,
  output logic [4:0]  ID_RS1,
  output logic [4:0]  ID_RS2,
  output logic [4:0]  ID_RD,
  output logic        PC_WRITE,
  output logic        ID_BUBBLE
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc_q;
  logic [31:0] pc_plus_four_q;
  logic        valid_q;
  logic        held_q;
  logic [31:0] hold_q;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        rs1_match;
  logic        rs2_match;
  logic        stall;

  // While the PC is frozen, memory re-reads the fetch address, so the word
  // belonging to ID_PC must come from the hold register instead of IMEM_DOUT.
  always_comb begin
    instr = NOP_INSTR;
    if (valid_q) begin
      instr = held_q ? hold_q : IMEM_DOUT;
    end
  end

  assign opcode    = instr[6:0];
  assign uses_rs1  = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2  = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign rs1_match = uses_rs1 && (EX_RD == instr[19:15]);
  assign rs2_match = uses_rs2 && (EX_RD == instr[24:20]);

  // A flush kills the dependent instruction, so it never needs to wait.
  assign stall = valid_q && EX_MEM_READ && (EX_RD != 5'd0)
                 && (rs1_match || rs2_match) && !FLUSH;

  always_ff @(posedge ID_CLK or negedge ID_RESET_N) begin
    if (!ID_RESET_N) begin
      pc_q           <= RESET_PC;
      pc_plus_four_q <= 32'd0;
      valid_q        <= 1'b0;
      held_q         <= 1'b0;
      hold_q         <= NOP_INSTR;
    end else if (FLUSH) begin
      pc_q           <= IF_PC;
      pc_plus_four_q <= IF_PC_PLUS_FOUR;
      valid_q        <= 1'b0;
      held_q         <= 1'b0;
    end else if (stall) begin
      if (!held_q) begin
        hold_q <= IMEM_DOUT;
        held_q <= 1'b1;
      end
    end else begin
      pc_q           <= IF_PC;
      pc_plus_four_q <= IF_PC_PLUS_FOUR;
      valid_q        <= 1'b1;
      held_q         <= 1'b0;
    end
  end

  assign ID_PC           = pc_q;
  assign ID_PC_PLUS_FOUR = pc_plus_four_q;
  assign ID_INSTR        = instr;
  assign ID_VALID        = valid_q && !FLUSH;
  assign ID_RS1          = instr[19:15];
  assign ID_RS2          = instr[24:20];
  assign ID_RD           = instr[11:7];
  assign PC_WRITE        = !stall;
  assign ID_BUBBLE       = stall || FLUSH;

endmodule

// File: tb/tb_fetch_decode_latch.sv
// tb/tb_fetch_decode_latch.sv - directed and random bench for fetch_decode_latch
module tb_fetch_decode_latch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, if_pc4, imem_dout;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rd;
  logic [31:0] id_pc, id_pc4, id_instr;
  logic        id_valid, pc_write, id_bubble;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  fetch_decode_latch dut (
    .ID_CLK(clk), .ID_RESET_N(rst_n), .IF_PC(if_pc), .IF_PC_PLUS_FOUR(if_pc4),
    .IMEM_DOUT(imem_dout), .FLUSH(flush), .EX_MEM_READ(ex_mem_read), .EX_RD(ex_rd),
    .ID_PC(id_pc), .ID_PC_PLUS_FOUR(id_pc4), .ID_INSTR(id_instr), .ID_VALID(id_valid),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_RD(id_rd), .PC_WRITE(pc_write), .ID_BUBBLE(id_bubble)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] imem [64];

  // Model of the ID slot: which PC sits in decode and the memory word fetched for it.
  logic        m_valid;
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_frozen;
  logic [31:0] fpc, target, junk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return imem[addr[7:2]];
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
      7'b0110011, 7'b0100011, 7'b1100011: return (r == ins[19:15]) || (r == ins[24:20]);
      default:                            return r == ins[19:15];
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [4:0] a, b, d;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    return {7'($urandom), b, a, 3'($urandom), d, ops[$urandom_range(0, 8)]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = 32'd0;
    m_pc4    = 32'd0;
    m_instr  = NOP;
    m_frozen = 1'b0;
  endtask

  // Drive one cycle, check the combinational view, then advance the model at the edge.
  task automatic cyc(input logic f, input logic rd_en, input logic [4:0] rd, input logic [31:0] tgt);
    logic [31:0] e_instr;
    bit          e_stall;
    flush       = f;
    ex_mem_read = rd_en;
    ex_rd       = rd;
    if_pc       = fpc;
    if_pc4      = fpc + 32'd4;
    imem_dout   = m_frozen ? junk : mem_word(m_pc);
    #1;
    e_instr = m_valid ? m_instr : NOP;
    e_stall = m_valid && rd_en && (rd != 5'd0) && reads_reg(e_instr, rd) && !f;
    chk("id_pc", id_pc, m_pc);
    chk("id_pc4", id_pc4, m_pc4);
    chk("id_instr", id_instr, e_instr);
    chk("id_valid", 32'(id_valid), 32'(m_valid && !f));
    chk("id_rs1", 32'(id_rs1), 32'(e_instr[19:15]));
    chk("id_rs2", 32'(id_rs2), 32'(e_instr[24:20]));
    chk("id_rd", 32'(id_rd), 32'(e_instr[11:7]));
    chk("pc_write", 32'(pc_write), 32'(!e_stall));
    chk("id_bubble", 32'(id_bubble), 32'(e_stall || f));
    @(posedge clk);
    if (f) begin
      m_valid  = 1'b0;
      m_pc     = fpc;
      m_pc4    = fpc + 32'd4;
      m_frozen = 1'b0;
      fpc      = tgt;
    end else if (e_stall) begin
      m_frozen = 1'b1;
    end else begin
      m_valid  = 1'b1;
      m_pc     = fpc;
      m_pc4    = fpc + 32'd4;
      m_instr  = mem_word(fpc);
      m_frozen = 1'b0;
      fpc      = fpc + 32'd4;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = rand_instr();
    imem[0]  = 32'h0052_8133;
    imem[3]  = 32'h0052_8133;
    imem[4]  = 32'h0000_52B7;
    imem[5]  = 32'h0000_0033;
    imem[32] = 32'h0052_8133;
    junk = 32'hDEAD_BEEF;
    model_reset();
    fpc = 32'd0;
    rst_n = 1'b0;
    flush = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5;
    if_pc = 32'd0; if_pc4 = 32'd4; imem_dout = 32'h0052_8133;
    #2;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_bubble", 32'(id_bubble), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b0, 1'b0, 5'd0, 32'd0);          // first edge after release captures 0x0
    cyc(1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0);          // ID_PC=0x8
    cyc(1'b0, 1'b1, 5'd5, 32'd0);          // load-use on add x2,x5,x5 at 0xC
    cyc(1'b0, 1'b0, 5'd0, 32'd0);          // held word despite 0xDEADBEEF
    cyc(1'b0, 1'b1, 5'd5, 32'd0);          // LUI: no stall
    cyc(1'b0, 1'b1, 5'd0, 32'd0);          // EX_RD=0: no stall
    cyc(1'b1, 1'b0, 5'd0, 32'h80);         // flush
    cyc(1'b0, 1'b0, 5'd0, 32'd0);          // dead slot
    cyc(1'b1, 1'b1, 5'd5, 32'h100);        // flush wins over stall
    cyc(1'b0, 1'b0, 5'd0, 32'd0);          // dead slot
    cyc(1'b0, 1'b1, 5'd5, 32'd0);          // stall at 0x100, now held

    flush = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5;
    imem_dout = junk;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_pc", id_pc, 32'd0);
    chk("arst_instr", id_instr, NOP);
    chk("arst_pc_write", 32'(pc_write), 32'd1);
    chk("arst_bubble", 32'(id_bubble), 32'd0);
    model_reset();
    fpc = 32'hFFFF_FFF0;                    // exercises PC wrap-around
    #3;
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic f;
      f    = ($urandom_range(0, 9) == 0);
      junk = $urandom;
      cyc(f, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
